pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor; successor to the single-cycle 32-bit registered adder in the datapath.
- Operand width and pipeline depth are generalised.
- Adds an add/sub mode, carry and signed-overflow flags, and a valid/ready handshake with backpressure.
- Sits between operand-select muxes and the ALU result bus; serves PC+4, branch-target and ALU add/sub paths.

---
 rtl/pipelined_addsub_if.sv | 23 ++
 rtl/pipelined_addsub.sv | 76 +++++++
 tb/tb_pipelined_addsub.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result handshake bundle between the source, the adder pipeline and the consumer.
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             carry_out;
  logic             overflow;
  modport master (
    output in_valid, in1, in2, op, out_ready,
    input  in_ready, out_valid, out, carry_out, overflow
  );
  modport slave (
    input  in_valid, in1, in2, op, out_ready,
    output in_ready, out_valid, out, carry_out, overflow
  );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep slice-per-stage add/sub with carry and signed-overflow flags.
// The whole pipe advances together; a stalled result at the output freezes every stage.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int SW = WIDTH / STAGES;
  logic adv;
  logic ovf_d, ovf_q;
  for (genvar g = 0; g < STAGES; g++) begin : g_st
    logic [WIDTH-1:0]      sa, nx, x_d, x_q;
    logic [WIDTH-g*SW-1:0] sbr;
    logic [SW:0]           sum;
    logic                  sc, sv, ld, c_d, c_q, v_d, v_q;
    if (g == 0) begin : g_in
      assign sa  = bus.in1;
      assign sbr = bus.op ? ~bus.in2 : bus.in2;
      assign sc  = bus.op;
      assign sv  = bus.in_valid;
    end else begin : g_prev
      // x_q holds finished low result slices below still-unused upper A slices
      assign sa  = g_st[g-1].x_q;
      assign sbr = g_st[g-1].g_b.b_q;
      assign sc  = g_st[g-1].c_q;
      assign sv  = g_st[g-1].v_q;
    end
    assign sum = {1'b0, sa[g*SW +: SW]} + {1'b0, sbr[SW-1:0]} + {{SW{1'b0}}, sc};
    assign ld  = adv && sv;
    always_comb begin
      nx = sa;
      nx[g*SW +: SW] = sum[SW-1:0];
    end
    // data only loads with a valid op so bubbles leave the last result visible
    assign x_d = ld ? nx : x_q;
    assign c_d = ld ? sum[SW] : c_q;
    assign v_d = adv ? sv : v_q;
    if (g < STAGES - 1) begin : g_b
      logic [WIDTH-(g+1)*SW-1:0] b_d, b_q;
      assign b_d = ld ? sbr[WIDTH-g*SW-1:SW] : b_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) b_q <= '0;
        else        b_q <= b_d;
      end
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        x_q <= '0;
        c_q <= 1'b0;
      end else begin
        v_q <= v_d;
        x_q <= x_d;
        c_q <= c_d;
      end
    end
  end
  assign adv = !(g_st[STAGES-1].v_q && !bus.out_ready);
  // carry into the MSB is recovered as a ^ b ^ sum at that bit
  assign ovf_d = g_st[STAGES-1].ld
               ? (g_st[STAGES-1].sa[WIDTH-1] ^ g_st[STAGES-1].sbr[SW-1] ^
                  g_st[STAGES-1].sum[SW-1] ^ g_st[STAGES-1].sum[SW])
               : ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign bus.in_ready  = adv;
  assign bus.out_valid = g_st[STAGES-1].v_q;
  assign bus.out       = g_st[STAGES-1].x_q;
  assign bus.carry_out = g_st[STAGES-1].c_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed 32-bit/2-stage checks plus random 16-bit sweeps at 1 and 4 stages.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;

  pipelined_addsub_if #(.WIDTH(32)) a ();
  pipelined_addsub_if #(.WIDTH(16)) b1 ();
  pipelined_addsub_if #(.WIDTH(16)) b4 ();
  pipelined_addsub #(.WIDTH(32), .STAGES(2)) u32 (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  pipelined_addsub #(.WIDTH(16), .STAGES(1)) u16s1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  pipelined_addsub #(.WIDTH(16), .STAGES(4)) u16s4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

  logic        r_vld[2], r_op[2], r_ordy;
  logic [15:0] r_in1[2], r_in2[2];
  logic        rv[2], ir[2], rc[2], rf[2];
  logic [15:0] ro[2];
  assign b1.in_valid = r_vld[0];
  assign b1.in1 = r_in1[0];
  assign b1.in2 = r_in2[0];
  assign b1.op = r_op[0];
  assign b1.out_ready = r_ordy;
  assign b4.in_valid = r_vld[1];
  assign b4.in1 = r_in1[1];
  assign b4.in2 = r_in2[1];
  assign b4.op = r_op[1];
  assign b4.out_ready = r_ordy;
  assign rv[0] = b1.out_valid;
  assign ir[0] = b1.in_ready;
  assign ro[0] = b1.out;
  assign rc[0] = b1.carry_out;
  assign rf[0] = b1.overflow;
  assign rv[1] = b4.out_valid;
  assign ir[1] = b4.in_ready;
  assign ro[1] = b4.out;
  assign rc[1] = b4.carry_out;
  assign rf[1] = b4.overflow;

  typedef struct {
    longint r;
    bit     c;
    bit     o;
    int     a;
  } exp_t;
  exp_t q0[$], q1[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference: unsigned carry/borrow and signed range test on plain integers
  function automatic void model(input int w, input longint ua, input longint ub, input bit op,
                                output longint r, output bit c, output bit o);
    longint m, s, sa, sb, ss;
    m  = longint'(1) << w;
    s  = op ? ua - ub + m : ua + ub;
    c  = op ? (ua >= ub) : (s >= m);
    r  = s % m;
    sa = ua >= m / 2 ? ua - m : ua;
    sb = ub >= m / 2 ? ub - m : ub;
    ss = op ? sa - sb : sa + sb;
    o  = (ss >= m / 2) || (ss < -(m / 2));
  endfunction

  task automatic run1(input string tag, input logic [31:0] x, input logic [31:0] y, input logic o,
                      input logic [31:0] er, input logic ec, input logic eo);
    a.in_valid = 1'b1;
    a.in1 = x;
    a.in2 = y;
    a.op = o;
    tick();
    a.in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, a.out_valid, 1'b1);
    chk({tag, "_out"}, a.out, er);
    chk({tag, "_carry"}, a.carry_out, ec);
    chk({tag, "_ovf"}, a.overflow, eo);
    tick();
  endtask

  initial begin
    longint   got[$];
    int       idx, stall, stale, sent[2], recv[2], advcnt[2];
    bit       seen, acc[2], mc, mo;
    longint   mr;
    exp_t     e;
    a.in_valid = 1'b0;
    a.in1 = '0;
    a.in2 = '0;
    a.op = 1'b0;
    a.out_ready = 1'b1;
    r_ordy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      r_vld[d] = 1'b0;
      r_op[d] = 1'b0;
      r_in1[d] = '0;
      r_in2[d] = '0;
      sent[d] = 0;
      recv[d] = 0;
      advcnt[d] = 0;
      acc[d] = 1'b0;
    end
    #3;
    chk("rst_valid", a.out_valid, 1'b0);
    chk("rst_out", a.out, 32'h0);
    chk("rst_carry", a.carry_out, 1'b0);
    chk("rst_ovf", a.overflow, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", a.in_ready, 1'b1);

    a.in_valid = 1'b1;
    a.in1 = 32'd2;
    a.in2 = 32'd20;
    tick();
    a.in1 = 32'd25;
    a.in2 = 32'd5;
    tick();
    chk("t1_valid_a", a.out_valid, 1'b1);
    chk("t1_out_a", a.out, 32'd22);
    chk("t1_flags_a", {a.carry_out, a.overflow}, 2'b00);
    a.in_valid = 1'b0;
    tick();
    chk("t1_valid_b", a.out_valid, 1'b1);
    chk("t1_out_b", a.out, 32'd30);
    chk("t1_flags_b", {a.carry_out, a.overflow}, 2'b00);
    tick();
    chk("t1_bubble_valid", a.out_valid, 1'b0);
    chk("t1_bubble_hold", a.out, 32'd30);

    run1("t2_ovf", 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run1("t2_carry", 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0);
    run1("t3_neg", 32'd5, 32'd7, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run1("t3_ovf", 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    idx = 0;
    stall = 0;
    seen = 1'b0;
    for (int t = 0; t < 16; t++) begin
      a.in_valid = idx < 4;
      a.in1 = 32'(idx + 1);
      a.in2 = 32'(idx + 1);
      a.op = 1'b0;
      if (a.out_valid && !seen) begin
        seen = 1'b1;
        stall = 3;
      end
      a.out_ready = stall == 0;
      #1;
      if (stall > 0) begin
        chk("t4_in_ready_low", a.in_ready, 1'b0);
        chk("t4_hold_valid", a.out_valid, 1'b1);
        chk("t4_hold_out", a.out, 32'd2);
        stall--;
      end
      if (a.out_valid && a.out_ready) got.push_back(longint'(a.out));
      acc[0] = a.in_valid && a.in_ready;
      tick();
      if (acc[0]) idx++;
    end
    a.in_valid = 1'b0;
    a.out_ready = 1'b1;
    chk("t4_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk($sformatf("t4_res%0d", i), got[i], 2 * (i + 1));

    a.in_valid = 1'b1;
    a.in1 = 32'h80000000;
    a.in2 = 32'h80000001;
    tick();
    a.in1 = 32'd9;
    a.in2 = 32'd9;
    tick();
    a.in_valid = 1'b0;
    chk("t5_pre_out", a.out, 32'h1);
    chk("t5_pre_flags", {a.carry_out, a.overflow}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", a.out_valid, 1'b0);
    chk("t5_async_out", a.out, 32'h0);
    chk("t5_async_flags", {a.carry_out, a.overflow}, 2'b00);
    tick();
    rst_n = 1'b1;
    stale = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (a.out_valid) stale++;
    end
    chk("t5_no_stale", stale, 0);
    a.in_valid = 1'b1;
    a.in1 = 32'd3;
    a.in2 = 32'd4;
    tick();
    a.in_valid = 1'b0;
    chk("t5_lat_early", a.out_valid, 1'b0);
    tick();
    chk("t5_fresh_valid", a.out_valid, 1'b1);
    chk("t5_fresh_out", a.out, 32'd7);

    for (int cyc = 0; cyc < 5000 && (recv[0] < 200 || recv[1] < 200); cyc++) begin
      for (int d = 0; d < 2; d++)
        if (!r_vld[d] && sent[d] < 200 && $urandom_range(3) != 0) begin
          r_vld[d] = 1'b1;
          r_in1[d] = 16'($urandom);
          r_in2[d] = 16'($urandom);
          r_op[d] = 1'($urandom);
        end
      r_ordy = $urandom_range(3) != 0;
      #1;
      for (int d = 0; d < 2; d++) begin
        if (rv[d] && r_ordy) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) chk($sformatf("rand%0d_spurious", d), 1'b1, 1'b0);
          else begin
            e = d == 0 ? q0.pop_front() : q1.pop_front();
            chk($sformatf("rand%0d_out", d), ro[d], e.r);
            chk($sformatf("rand%0d_carry", d), rc[d], e.c);
            chk($sformatf("rand%0d_ovf", d), rf[d], e.o);
            chk($sformatf("rand%0d_latency", d), advcnt[d] - e.a, d == 0 ? 1 : 4);
          end
          recv[d]++;
        end
        acc[d] = r_vld[d] && ir[d];
        if (acc[d]) begin
          model(16, longint'(r_in1[d]), longint'(r_in2[d]), r_op[d], mr, mc, mo);
          e = '{mr, mc, mo, advcnt[d]};
          if (d == 0) q0.push_back(e);
          else q1.push_back(e);
          sent[d]++;
        end
        advcnt[d] += int'(ir[d]);
      end
      tick();
      for (int d = 0; d < 2; d++) if (acc[d]) r_vld[d] = 1'b0;
    end
    chk("rand0_count", recv[0], 200);
    chk("rand1_count", recv[1], 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
